// File: rtl/vram_port_arbiter.sv
// rtl/vram_port_arbiter.sv - single-port VRAM arbiter between CPU data port and display fetcher
module vram_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wen,
    output logic              ram_ren,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              owner
);

    localparam int WCNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int SCNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(RD_LATENCY - 1);
    localparam logic [SCNT_W-1:0] SCNT_MAX  = SCNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic              wen_q,       wen_d;
    logic              owner_q,     owner_d;
    logic [SCNT_W-1:0] starve_q,    starve_d;
    logic [WCNT_W-1:0] wcnt_q,      wcnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;

    logic grant_vga;

    // Display wins unless the CPU has waited through STARVE_MAX display grants.
    assign grant_vga = vga_req && (!cpu_req || (starve_q < SCNT_MAX));

    // State and datapath registers; reset discards any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wen_q       <= 1'b0;
            owner_q     <= 1'b0;
            starve_q    <= '0;
            wcnt_q      <= '0;
            cpu_rdata_q <= '0;
            vga_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wen_q       <= wen_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            wcnt_q      <= wcnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            vga_rdata_q <= vga_rdata_d;
        end
    end

    // Next-state logic: requests are sampled only in IDLE, everything else runs to completion.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wen_d       = wen_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        wcnt_d      = wcnt_q;
        cpu_rdata_d = cpu_rdata_q;
        vga_rdata_d = vga_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (vga_req || cpu_req) begin
                    state_d = ST_ACCESS;
                    if (grant_vga) begin
                        addr_d  = vga_addr;
                        wen_d   = 1'b0;
                        owner_d = 1'b1;
                        if (!cpu_req) begin
                            starve_d = '0;
                        end else if (starve_q != SCNT_MAX) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end else begin
                        addr_d   = cpu_addr;
                        wdata_d  = cpu_wdata;
                        wen_d    = cpu_wen;
                        owner_d  = 1'b0;
                        starve_d = '0;
                    end
                end
            end
            ST_ACCESS: begin
                wcnt_d  = '0;
                state_d = wen_q ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (wcnt_q == WCNT_LAST) begin
                    state_d = ST_RESP;
                    if (owner_q) begin
                        vga_rdata_d = ram_rdata;
                    end else begin
                        cpu_rdata_d = ram_rdata;
                    end
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_wen   = (state_q == ST_ACCESS) &&  wen_q;
    assign ram_ren   = (state_q == ST_ACCESS) && !wen_q;
    assign cpu_ack   = (state_q == ST_RESP)   && !owner_q;
    assign vga_valid = (state_q == ST_RESP)   &&  owner_q;
    assign cpu_rdata = cpu_rdata_q;
    assign vga_rdata = vga_rdata_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb/tb_vram_port_arbiter.sv - directed self-checking bench for vram_port_arbiter
module tb_vram_port_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        vga_req;
    logic [31:0] vga_addr;
    logic [31:0] vga_rdata;
    logic        vga_valid;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_wen;
    logic        ram_ren;
    logic [31:0] ram_rdata;
    logic        owner;

    int n_checks;
    int n_fail;

    vram_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .RD_LATENCY(1),
        .STARVE_MAX(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .cpu_wen  (cpu_wen),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ack  (cpu_ack),
        .vga_req  (vga_req),
        .vga_addr (vga_addr),
        .vga_rdata(vga_rdata),
        .vga_valid(vga_valid),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_wen  (ram_wen),
        .ram_ren  (ram_ren),
        .ram_rdata(ram_rdata),
        .owner    (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_wen   = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        vga_req   = 1'b0;
        vga_addr  = '0;
        ram_rdata = 32'hFFFF_FFFF;
        step();
        step();
        n_checks++;
        if ({cpu_ack, vga_valid, ram_wen, ram_ren, owner} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 00000", {cpu_ack, vga_valid, ram_wen, ram_ren, owner});
        end
        n_checks++;
        if ({ram_addr, ram_wdata, cpu_rdata, vga_rdata} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", {ram_addr, ram_wdata, cpu_rdata, vga_rdata});
        end
        rst = 1'b0;
        step();
        n_checks++;
        if ({cpu_ack, vga_valid, ram_wen, ram_ren} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected 0000", {cpu_ack, vga_valid, ram_wen, ram_ren});
        end
    endtask

    task automatic test_cpu_write();
        cpu_req   = 1'b1;
        cpu_wen   = 1'b1;
        cpu_addr  = 32'h2000_0010;
        cpu_wdata = 32'hDEAD_BEEF;
        step();
        n_checks++;
        if ({ram_wen, ram_ren, cpu_ack} !== 3'b100) begin
            n_fail++;
            $display("FAIL wr_access_strobe: got %b expected 100", {ram_wen, ram_ren, cpu_ack});
        end
        n_checks++;
        if ({ram_addr, ram_wdata} !== {32'h2000_0010, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL wr_access_bus: got %h %h expected 20000010 deadbeef", ram_addr, ram_wdata);
        end
        step();
        n_checks++;
        if ({cpu_ack, vga_valid, ram_wen} !== 3'b100) begin
            n_fail++;
            $display("FAIL wr_ack: got %b expected 100", {cpu_ack, vga_valid, ram_wen});
        end
        cpu_req = 1'b0;
        step();
        n_checks++;
        if ({cpu_ack, ram_wen, ram_addr} !== {2'b00, 32'h2000_0010}) begin
            n_fail++;
            $display("FAIL wr_after_ack: got %b %h expected 00 20000010", {cpu_ack, ram_wen}, ram_addr);
        end
    endtask

    task automatic test_cpu_read();
        cpu_req  = 1'b1;
        cpu_wen  = 1'b0;
        cpu_addr = 32'h2000_0020;
        step();
        n_checks++;
        if ({ram_ren, ram_wen, ram_addr} !== {2'b10, 32'h2000_0020}) begin
            n_fail++;
            $display("FAIL rd_access: got %b %h expected 10 20000020", {ram_ren, ram_wen}, ram_addr);
        end
        step();
        ram_rdata = 32'h1234_5678;
        n_checks++;
        if ({cpu_ack, ram_ren} !== 2'b00) begin
            n_fail++;
            $display("FAIL rd_wait: got %b expected 00", {cpu_ack, ram_ren});
        end
        step();
        n_checks++;
        if ({cpu_ack, cpu_rdata} !== {1'b1, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL rd_ack_data: got %b %h expected 1 12345678", cpu_ack, cpu_rdata);
        end
        n_checks++;
        if (vga_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rd_vga_untouched: got %h expected 0", vga_rdata);
        end
        cpu_req   = 1'b0;
        ram_rdata = 32'h0BAD_0BAD;
        step();
        step();
        n_checks++;
        if ({cpu_ack, cpu_rdata} !== {1'b0, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL rd_hold: got %b %h expected 0 12345678", cpu_ack, cpu_rdata);
        end
    endtask

    task automatic test_simultaneous();
        cpu_req   = 1'b1;
        cpu_wen   = 1'b0;
        cpu_addr  = 32'h2000_0100;
        vga_req   = 1'b1;
        vga_addr  = 32'h2000_8000;
        ram_rdata = 32'hA5A5_0001;
        step();
        n_checks++;
        if ({owner, ram_ren, ram_addr} !== {2'b11, 32'h2000_8000}) begin
            n_fail++;
            $display("FAIL sim_vga_first: got %b %h expected 11 20008000", {owner, ram_ren}, ram_addr);
        end
        step();
        step();
        n_checks++;
        if ({vga_valid, cpu_ack, vga_rdata} !== {2'b10, 32'hA5A5_0001}) begin
            n_fail++;
            $display("FAIL sim_vga_resp: got %b %h expected 10 a5a50001", {vga_valid, cpu_ack}, vga_rdata);
        end
        n_checks++;
        if (cpu_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL sim_cpu_rdata_untouched: got %h expected 12345678", cpu_rdata);
        end
        vga_req   = 1'b0;
        ram_rdata = 32'h5A5A_0002;
        step();
        step();
        n_checks++;
        if ({owner, ram_ren, ram_addr} !== {2'b01, 32'h2000_0100}) begin
            n_fail++;
            $display("FAIL sim_cpu_second: got %b %h expected 01 20000100", {owner, ram_ren}, ram_addr);
        end
        step();
        step();
        n_checks++;
        if ({cpu_ack, vga_valid, cpu_rdata, vga_rdata} !== {2'b10, 32'h5A5A_0002, 32'hA5A5_0001}) begin
            n_fail++;
            $display("FAIL sim_cpu_resp: got %b %h %h expected 10 5a5a0002 a5a50001",
                     {cpu_ack, vga_valid}, cpu_rdata, vga_rdata);
        end
        cpu_req = 1'b0;
        step();
    endtask

    task automatic test_starvation();
        int  events [10];
        int  n_ev;
        int  cycles;
        int  exp_ev;
        n_ev   = 0;
        cycles = 0;
        cpu_req   = 1'b1;
        cpu_wen   = 1'b0;
        vga_req   = 1'b1;
        ram_rdata = 32'h0000_7777;
        while (n_ev < 10 && cycles < 80) begin
            step();
            cycles++;
            if (cpu_ack && vga_valid) begin
                n_checks++;
                n_fail++;
                $display("FAIL starve_double_pulse: got ack=1 valid=1 expected one pulse");
            end
            if (vga_valid) begin
                events[n_ev] = 1;
                n_ev++;
            end else if (cpu_ack) begin
                events[n_ev] = 0;
                n_ev++;
            end
            if (n_ev == 10) begin
                cpu_req = 1'b0;
                vga_req = 1'b0;
            end
        end
        n_checks++;
        if (n_ev != 10) begin
            n_fail++;
            $display("FAIL starve_timeout: got %0d events expected 10", n_ev);
        end
        for (int i = 0; i < n_ev; i++) begin
            exp_ev = (i % 5 == 4) ? 0 : 1;
            n_checks++;
            if (events[i] !== exp_ev) begin
                n_fail++;
                $display("FAIL starve_seq[%0d]: got owner %0d expected %0d", i, events[i], exp_ev);
            end
        end
        step();
    endtask

    task automatic test_reset_midflight();
        int acks;
        acks      = 0;
        cpu_req   = 1'b1;
        cpu_wen   = 1'b0;
        cpu_addr  = 32'h2000_0200;
        ram_rdata = 32'hCAFE_F00D;
        step();
        step();
        rst     = 1'b1;
        cpu_req = 1'b0;
        #1;
        n_checks++;
        if ({cpu_ack, vga_valid, ram_wen, ram_ren, owner} !== 5'b0) begin
            n_fail++;
            $display("FAIL midreset_strobes: got %b expected 00000", {cpu_ack, vga_valid, ram_wen, ram_ren, owner});
        end
        n_checks++;
        if ({ram_addr, ram_wdata, cpu_rdata, vga_rdata} !== 128'h0) begin
            n_fail++;
            $display("FAIL midreset_data: got %h expected 0", {ram_addr, ram_wdata, cpu_rdata, vga_rdata});
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (cpu_ack) acks++;
        end
        n_checks++;
        if (acks != 0) begin
            n_fail++;
            $display("FAIL midreset_no_ack: got %0d acks expected 0", acks);
        end
        cpu_req   = 1'b1;
        cpu_wen   = 1'b1;
        cpu_addr  = 32'h2000_0300;
        cpu_wdata = 32'h0000_00AA;
        step();
        n_checks++;
        if ({ram_wen, ram_addr, ram_wdata} !== {1'b1, 32'h2000_0300, 32'h0000_00AA}) begin
            n_fail++;
            $display("FAIL midreset_wr_access: got %b %h %h expected 1 20000300 000000aa", ram_wen, ram_addr, ram_wdata);
        end
        step();
        n_checks++;
        if (cpu_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_wr_ack: got %b expected 1", cpu_ack);
        end
        cpu_req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic exp_ack;
        logic exp_wen;
        cpu_req   = 1'b1;
        cpu_wen   = 1'b1;
        cpu_addr  = 32'h2000_0400;
        cpu_wdata = 32'h5555_AAAA;
        for (int k = 1; k <= 11; k++) begin
            step();
            exp_ack = (k % 3 == 2);
            exp_wen = (k % 3 == 1);
            n_checks++;
            if ({cpu_ack, ram_wen} !== {exp_ack, exp_wen}) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got ack/wen %b expected %b", k, {cpu_ack, ram_wen}, {exp_ack, exp_wen});
            end
        end
        cpu_req = 1'b0;
        step();
        step();
        n_checks++;
        if ({cpu_ack, ram_wen} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_stop: got %b expected 00", {cpu_ack, ram_wen});
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_simultaneous();
        test_starvation();
        test_reset_midflight();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
